// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the round-robin RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned NUM_REQ_MIN    = 2;
  localparam int unsigned NUM_REQ_MAX    = 8;

  // Width of a requester index; never below 1 so vectors stay legal.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted req at or after rr_ptr wins.
module rr_priority_picker
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned IW = ID_W + 1;

  logic [IW-1:0] idx;
  logic          found;

  // Walk the requesters in rotated order; the wrap keeps idx below NUM_REQ.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if (!found && (idx == IW'(j)) && req[j]) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  output logic                          ram_we,
  input  logic [DATA_WIDTH-1:0]         ram_q
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ID_W-1:0]       rd_id_q, rd_id_d;
  logic [NUM_REQ-1:0]    pick;
  logic                  any_gnt;
  logic [ID_W-1:0]       win_id;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick)
  );

  // No grant may escape while reset is held, whatever the requesters do.
  assign gnt     = rst_n ? pick : '0;
  assign any_gnt = |gnt;

  // One-hot grant to winner index and its request payload.
  always_comb begin
    win_id    = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        win_id    = ID_W'(i);
        win_we    = req_we[i];
        win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // RAM port is driven only on a grant; idle presents zeros.
  assign ram_we    = any_gnt & win_we;
  assign ram_addr  = any_gnt ? win_addr  : '0;
  assign ram_wdata = any_gnt ? win_wdata : '0;

  // Pointer advance and read-pipeline bookkeeping.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    if (any_gnt) begin
      rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
      if (!win_we) begin
        rd_pend_d = 1'b1;
        rd_id_d   = win_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // RAM q is already registered, so the return path is a qualified pass-through.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rvalid[i] = rd_pend_q && (rd_id_q == ID_W'(i));
    end
  end

  assign rdata = rd_pend_q ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM.
module tb_ram_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_we;
  logic [DW-1:0]   ram_q;

  logic [DW-1:0] mem [256];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Single-port RAM: registered q returning pre-write contents.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic set_slot(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111; req_we = 4'b1111;
    for (int i = 0; i < int'(N); i++) set_slot(i, 1'b1, AW'(8'h50 + i), DW'(8'hE0 + i));
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b0000) begin $display("FAIL reset_gnt: got %b want 0000", gnt); err_cnt++; end
    vec_cnt++;
    if (ram_we !== 1'b0) begin $display("FAIL reset_ram_we: got %b want 0", ram_we); err_cnt++; end
    vec_cnt++;
    if (rvalid !== 4'b0000 || rdata !== 8'h00) begin
      $display("FAIL reset_rvalid: got %b/%h want 0000/00", rvalid, rdata); err_cnt++;
    end
    rst_n = 1'b1;
    #1;
    vec_cnt++;
    if (gnt !== 4'b0001) begin $display("FAIL reset_first_gnt: got %b want 0001", gnt); err_cnt++; end
    req = '0; req_we = '0;
    #1;
    vec_cnt++;
    if (ram_addr !== 8'h00 || ram_wdata !== 8'h00 || ram_we !== 1'b0) begin
      $display("FAIL idle_ram_port: got %h/%h/%b want 00/00/0", ram_addr, ram_wdata, ram_we); err_cnt++;
    end
    step();
  endtask

  task automatic test_write_read();
    do_reset();
    req = 4'b0001; set_slot(0, 1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b0001 || ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_wdata !== 8'hA5) begin
      $display("FAIL wr_grant: got %b/%b/%h/%h want 0001/1/10/a5", gnt, ram_we, ram_addr, ram_wdata);
      err_cnt++;
    end
    step();
    set_slot(0, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b0001 || ram_we !== 1'b0 || rvalid !== 4'b0000) begin
      $display("FAIL rd_grant: got %b/%b/%b want 0001/0/0000", gnt, ram_we, rvalid); err_cnt++;
    end
    step();
    req = '0;
    @(negedge clk);
    vec_cnt++;
    if (rvalid !== 4'b0001 || rdata !== 8'hA5) begin
      $display("FAIL rd_data: got %b/%h want 0001/a5", rvalid, rdata); err_cnt++;
    end
    step();
    @(negedge clk);
    vec_cnt++;
    if (rvalid !== 4'b0000) begin $display("FAIL rd_one_cycle: got %b want 0000", rvalid); err_cnt++; end
    step();
  endtask

  task automatic test_fairness();
    logic [N-1:0]  exp_g;
    logic [AW-1:0] exp_a;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < int'(N); i++) set_slot(i, 1'b1, AW'(8'h40 + i), DW'(8'hC0 + i));
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      exp_a = AW'(8'h40 + (c % 4));
      @(negedge clk);
      vec_cnt++;
      if (gnt !== exp_g || ram_addr !== exp_a) begin
        $display("FAIL fair_c%0d: got %b/%h want %b/%h", c, gnt, ram_addr, exp_g, exp_a); err_cnt++;
      end
      step();
    end
    req = '0;
  endtask

  task automatic test_sparse();
    do_reset();
    req = 4'b0010; set_slot(1, 1'b1, 8'h60, 8'h01);
    step();
    req = 4'b0011; set_slot(0, 1'b1, 8'h61, 8'h02);
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b0001) begin $display("FAIL sparse_wrap: got %b want 0001", gnt); err_cnt++; end
    step();
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b0010) begin $display("FAIL sparse_next: got %b want 0010", gnt); err_cnt++; end
    step();
    req = '0;
  endtask

  task automatic test_back_to_back();
    req = 4'b0010; set_slot(1, 1'b1, 8'h20, 8'h11);
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b0010) begin $display("FAIL b2b_wr1: got %b want 0010", gnt); err_cnt++; end
    step();
    req = 4'b1000; set_slot(3, 1'b1, 8'h30, 8'h33);
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b1000) begin $display("FAIL b2b_wr3: got %b want 1000", gnt); err_cnt++; end
    step();
    req = 4'b1010; set_slot(1, 1'b0, 8'h20, 8'h00); set_slot(3, 1'b0, 8'h30, 8'h00);
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b0010 || ram_addr !== 8'h20) begin
      $display("FAIL b2b_rd1: got %b/%h want 0010/20", gnt, ram_addr); err_cnt++;
    end
    step();
    req = 4'b1000;
    @(negedge clk);
    vec_cnt++;
    if (gnt !== 4'b1000 || rvalid !== 4'b0010 || rdata !== 8'h11) begin
      $display("FAIL b2b_rd3: got %b/%b/%h want 1000/0010/11", gnt, rvalid, rdata); err_cnt++;
    end
    step();
    req = '0;
    @(negedge clk);
    vec_cnt++;
    if (rvalid !== 4'b1000 || rdata !== 8'h33) begin
      $display("FAIL b2b_data3: got %b/%h want 1000/33", rvalid, rdata); err_cnt++;
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req = 4'b0001; set_slot(0, 1'b0, 8'h10, 8'h00);
    step();
    req = '0;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (rvalid !== 4'b0000 || rdata !== 8'h00) begin
      $display("FAIL midrst_drop: got %b/%h want 0000/00", rvalid, rdata); err_cnt++;
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (rvalid !== 4'b0000) begin
        $display("FAIL midrst_noreplay_c%0d: got %b want 0000", c, rvalid); err_cnt++;
      end
      step();
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    rst_n = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_write_read();
    test_fairness();
    test_sparse();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
